// File: rtl/enc_pack_sequencer.sv
// Issues the binder packs of one encoder sample in order, paced by the accumulator
// credit, and tags each issue through the binder latency for the accumulator.
module enc_pack_sequencer #(
  parameter int NUM_FEATURES    = 617,
  parameter int FEATURES_PER_CC = 62,
  parameter int NUM_PACKS       = 10,
  parameter int BIND_LAT        = 1,
  localparam int PACK_W = (NUM_PACKS > 1) ? $clog2(NUM_PACKS) : 1,
  localparam int CNT_W  = $clog2(FEATURES_PER_CC + 1)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  input  logic                 abort,
  input  logic                 acc_ready,
  output logic [NUM_PACKS-1:0] start_encoding,
  output logic [PACK_W-1:0]    feat_rd_addr,
  output logic                 out_valid,
  output logic [PACK_W-1:0]    out_pack,
  output logic [CNT_W-1:0]     out_feat_cnt,
  output logic                 out_last,
  output logic                 enc_done,
  output logic [15:0]          sample_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [PACK_W-1:0] LAST_PACK = PACK_W'(NUM_PACKS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FEATURES_PER_CC);
  localparam logic [CNT_W-1:0]  LAST_CNT  =
    CNT_W'(NUM_FEATURES - (NUM_PACKS - 1) * FEATURES_PER_CC);

  state_t              r_state, w_next;
  logic [PACK_W-1:0]   r_pack;
  logic [15:0]         r_sample_cnt;
  logic                r_tag_valid [BIND_LAT];
  logic [PACK_W-1:0]   r_tag_pack  [BIND_LAT];
  logic                r_tag_last  [BIND_LAT];
  logic                w_issue;
  logic                w_pack_last;

  assign w_pack_last = (r_pack == LAST_PACK);
  // Abort wins over a pending credit so nothing starts in the flush cycle.
  assign w_issue     = (r_state == S_ISSUE) && acc_ready && !abort;

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (sample_valid) w_next = S_ISSUE;
      S_ISSUE: if (w_issue && w_pack_last) w_next = S_DRAIN;
      S_DRAIN: if (out_valid && out_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_pack  <= '0;
    end else begin
      r_state <= w_next;
      if (abort || (r_state == S_IDLE && sample_valid)) r_pack <= '0;
      else if (w_issue) r_pack <= r_pack + PACK_W'(1);
    end
  end

  // NOTE: the tag pipeline is a handful of flops, not a memory, so every stage is
  // reset; a stale valid bit would otherwise fire out_valid after power-up.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < BIND_LAT; i++) begin
        r_tag_valid[i] <= 1'b0;
        r_tag_pack[i]  <= '0;
        r_tag_last[i]  <= 1'b0;
      end
    end else if (abort) begin
      for (int i = 0; i < BIND_LAT; i++) begin
        r_tag_valid[i] <= 1'b0;
        r_tag_pack[i]  <= '0;
        r_tag_last[i]  <= 1'b0;
      end
    end else begin
      r_tag_valid[0] <= w_issue;
      r_tag_pack[0]  <= w_issue ? r_pack : '0;
      r_tag_last[0]  <= w_issue && w_pack_last;
      for (int i = 1; i < BIND_LAT; i++) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_pack[i]  <= r_tag_pack[i-1];
        r_tag_last[i]  <= r_tag_last[i-1];
      end
    end
  end

  // Only written on a completed sample, so the count otherwise holds its value.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                              r_sample_cnt <= '0;
    else if (r_state == S_DONE && !abort)   r_sample_cnt <= r_sample_cnt + 16'd1;
  end

  assign sample_ready   = (r_state == S_IDLE);
  assign start_encoding = w_issue ? (NUM_PACKS'(1) << r_pack) : '0;
  assign feat_rd_addr   = r_pack;
  assign out_valid      = r_tag_valid[BIND_LAT-1];
  assign out_pack       = r_tag_pack[BIND_LAT-1];
  assign out_last       = r_tag_valid[BIND_LAT-1] && r_tag_last[BIND_LAT-1];
  assign out_feat_cnt   = !r_tag_valid[BIND_LAT-1] ? '0 :
                          r_tag_last[BIND_LAT-1]   ? LAST_CNT : FULL_CNT;
  assign enc_done       = (r_state == S_DONE) && !abort;
  assign sample_cnt     = r_sample_cnt;

endmodule

// File: tb/tb_enc_pack_sequencer.sv
// Bench for enc_pack_sequencer: expected issue/output/done cycles are derived from
// the credit pattern with plain arithmetic, plus a small single-pack config instance.
module tb_enc_pack_sequencer;

  localparam int NP  = 10;
  localparam int FPC = 62;
  localparam int NF  = 617;
  localparam int BL  = 1;
  localparam int PW  = $clog2(NP);
  localparam int CW  = $clog2(FPC + 1);

  logic          clk = 1'b0;
  logic          nrst;
  logic          sample_valid, abort, acc_ready;
  logic          sample_ready, out_valid, out_last, enc_done;
  logic [NP-1:0] start_encoding;
  logic [PW-1:0] feat_rd_addr, out_pack;
  logic [CW-1:0] out_feat_cnt;
  logic [15:0]   sample_cnt;

  logic          c_sample_valid, c_abort, c_acc_ready;
  logic          c_sample_ready, c_out_valid, c_out_last, c_enc_done;
  logic [0:0]    c_start_encoding, c_feat_rd_addr, c_out_pack;
  logic [CW-1:0] c_out_feat_cnt;
  logic [15:0]   c_sample_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  enc_pack_sequencer #(.NUM_FEATURES(NF), .FEATURES_PER_CC(FPC),
                       .NUM_PACKS(NP), .BIND_LAT(BL)) dut (
    .clk(clk), .nrst(nrst), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .abort(abort), .acc_ready(acc_ready), .start_encoding(start_encoding),
    .feat_rd_addr(feat_rd_addr), .out_valid(out_valid), .out_pack(out_pack),
    .out_feat_cnt(out_feat_cnt), .out_last(out_last), .enc_done(enc_done),
    .sample_cnt(sample_cnt));

  enc_pack_sequencer #(.NUM_FEATURES(40), .FEATURES_PER_CC(FPC),
                       .NUM_PACKS(1), .BIND_LAT(3)) u_cfg (
    .clk(clk), .nrst(nrst), .sample_valid(c_sample_valid), .sample_ready(c_sample_ready),
    .abort(c_abort), .acc_ready(c_acc_ready), .start_encoding(c_start_encoding),
    .feat_rd_addr(c_feat_rd_addr), .out_valid(c_out_valid), .out_pack(c_out_pack),
    .out_feat_cnt(c_out_feat_cnt), .out_last(c_out_last), .enc_done(c_enc_done),
    .sample_cnt(c_sample_cnt));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: credit always high; 1: repeating 1,0,0,1; 2: random ~40% low.
  task automatic run_sample(input int mode, input bit keep_valid, input bit noisy_valid,
                            input bit abort_at_done);
    int       issue_cyc [NP];
    bit       acc_pat [256];
    int       k, c, done_c, exp_pack;
    bit       exp_ov;
    logic [NP-1:0] exp_start;
    k = 0;
    c = 1;
    while (k < NP) begin
      case (mode)
        0:       acc_pat[c] = 1'b1;
        1:       acc_pat[c] = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
        default: acc_pat[c] = ($urandom_range(99) >= 40) || (c > 200);
      endcase
      if (acc_pat[c]) begin
        issue_cyc[k] = c;
        k++;
      end
      c++;
    end
    done_c = issue_cyc[NP-1] + BL + 1;
    for (int cy = 0; cy <= done_c; cy++) begin
      @(negedge clk);
      abort        = abort_at_done && (cy == done_c);
      sample_valid = (cy == 0) ? 1'b1 : (cy == done_c) ? keep_valid :
                     noisy_valid ? 1'($urandom_range(1)) : 1'b0;
      acc_ready    = (cy >= 1 && cy <= issue_cyc[NP-1]) ? acc_pat[cy] : 1'($urandom_range(1));
      #1;
      exp_start = '0;
      exp_ov    = 1'b0;
      exp_pack  = 0;
      for (int p = 0; p < NP; p++) begin
        if (issue_cyc[p] == cy) begin
          exp_start = NP'(1) << p;
          check("feat_rd_addr", 32'(feat_rd_addr), 32'(p));
        end
        if (issue_cyc[p] + BL == cy) begin
          exp_ov   = 1'b1;
          exp_pack = p;
        end
      end
      check("start_encoding", 32'(start_encoding), 32'(exp_start));
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      check("out_last", 32'(out_last), 32'(exp_ov && exp_pack == NP - 1));
      if (exp_ov) begin
        check("out_pack", 32'(out_pack), 32'(exp_pack));
        check("out_feat_cnt", 32'(out_feat_cnt),
              (exp_pack == NP - 1) ? 32'(NF - (NP - 1) * FPC) : 32'(FPC));
      end
      check("enc_done", 32'(enc_done), 32'(cy == done_c && !abort_at_done));
      check("sample_ready", 32'(sample_ready), 32'(cy == 0));
      if (cy == 0 || cy == done_c) check("sample_cnt", 32'(sample_cnt), 32'(exp_cnt));
    end
    if (!abort_at_done) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    sample_valid = 1'b0;
    abort        = 1'b0;
    acc_ready    = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(sample_ready), 32'd1);
    check({tag, "_start"}, 32'(start_encoding), 32'd0);
    check({tag, "_ov"}, 32'(out_valid), 32'd0);
    check({tag, "_done"}, 32'(enc_done), 32'd0);
    check({tag, "_cnt"}, 32'(sample_cnt), 32'(exp_cnt));
  endtask

  initial begin
    nrst = 1'b0;
    sample_valid = 1'b0; abort = 1'b0; acc_ready = 1'b1;
    c_sample_valid = 1'b0; c_abort = 1'b0; c_acc_ready = 1'b1;
    exp_cnt = '0;
    #1;
    check("rst_ready", 32'(sample_ready), 32'd1);
    check("rst_start", 32'(start_encoding), 32'd0);
    check("rst_addr", 32'(feat_rd_addr), 32'd0);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_pack", 32'(out_pack), 32'd0);
    check("rst_fcnt", 32'(out_feat_cnt), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_done", 32'(enc_done), 32'd0);
    check("rst_cnt", 32'(sample_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;

    // Single sample with full credit, then fixed and random stall patterns.
    run_sample(0, 1'b0, 1'b0, 1'b0);
    idle_check("after_first");
    run_sample(1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) run_sample(2, 1'b0, 1'b1, 1'b0);
    idle_check("after_stall");

    // Back-to-back with sample_valid held high through DONE.
    run_sample(0, 1'b1, 1'b1, 1'b0);
    run_sample(2, 1'b1, 1'b1, 1'b0);
    run_sample(0, 1'b0, 1'b1, 1'b0);

    // Abort after pack 4 has issued.
    for (int cy = 0; cy <= 6; cy++) begin
      @(negedge clk);
      sample_valid = (cy == 0) || (cy == 6);
      acc_ready    = 1'b1;
      abort        = (cy == 6);
      #1;
      if (cy >= 1 && cy <= 5) check("abort_issue", 32'(start_encoding), 32'(NP'(1) << (cy - 1)));
      if (cy == 6) begin
        check("abort_start", 32'(start_encoding), 32'd0);
        check("abort_ov", 32'(out_valid), 32'd1);
        check("abort_ovpack", 32'(out_pack), 32'd4);
      end
    end
    for (int i = 0; i < 4; i++) idle_check("post_abort");
    run_sample(2, 1'b0, 1'b0, 1'b0);

    // Abort landing on the DONE cycle suppresses enc_done and the count.
    run_sample(0, 1'b0, 1'b0, 1'b1);
    idle_check("abort_done");

    // Reset mid-ISSUE.
    @(negedge clk); sample_valid = 1'b1; acc_ready = 1'b1;
    @(negedge clk); sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); nrst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(sample_ready), 32'd1);
    check("mid_rst_start", 32'(start_encoding), 32'd0);
    check("mid_rst_addr", 32'(feat_rd_addr), 32'd0);
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_cnt", 32'(sample_cnt), 32'd0);
    @(negedge clk); nrst = 1'b1;
    exp_cnt = '0;
    idle_check("after_rst");
    run_sample(0, 1'b0, 1'b0, 1'b0);

    // Sample counter wrap.
    @(negedge clk);
    force dut.r_sample_cnt = 16'hFFFF;
    #1 release dut.r_sample_cnt;
    exp_cnt = 16'hFFFF;
    #1 check("force_cnt", 32'(sample_cnt), 32'hFFFF);
    run_sample(0, 1'b0, 1'b0, 1'b0);
    idle_check("wrap");

    // Single-pack configuration with BIND_LAT=3 and 40 features.
    for (int cy = 0; cy <= 6; cy++) begin
      @(negedge clk);
      c_sample_valid = (cy == 0);
      c_acc_ready    = 1'b1;
      #1;
      check("cfg_start", 32'(c_start_encoding), 32'(cy == 1));
      check("cfg_ov", 32'(c_out_valid), 32'(cy == 4));
      check("cfg_last", 32'(c_out_last), 32'(cy == 4));
      if (cy == 4) begin
        check("cfg_fcnt", 32'(c_out_feat_cnt), 32'd40);
        check("cfg_pack", 32'(c_out_pack), 32'd0);
      end
      check("cfg_done", 32'(c_enc_done), 32'(cy == 5));
      check("cfg_ready", 32'(c_sample_ready), 32'(cy == 0 || cy == 6));
    end
    check("cfg_cnt", 32'(c_sample_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
